// File: rtl/systolic_feeder.sv
// Edge feeder for the systolic GEMM array: buffers A (MxK) and B (KxN) from a
// valid/ready load port, then streams them as diagonal-skewed wavefronts.
//
// state  | meaning
// IDLE   | accepting load beats; waits for start with both matrices full
// STREAM | presenting wavefront t = 0..S-1, one per clock
// DONE   | one-cycle wrap-up: done pulse, pointers and full flags cleared
module systolic_feeder #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sel,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    start,
  output logic [M*DATA_WIDTH-1:0] a_edge,
  output logic [N*DATA_WIDTH-1:0] b_edge,
  output logic                    edge_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int DW   = DATA_WIDTH;
  localparam int S    = K + M + N - 2;
  localparam int A_SZ = M * K;
  localparam int B_SZ = K * N;
  localparam int AP_W = $clog2(A_SZ + 1);
  localparam int BP_W = $clog2(B_SZ + 1);
  localparam int AI_W = (A_SZ > 1) ? $clog2(A_SZ) : 1;
  localparam int BI_W = (B_SZ > 1) ? $clog2(B_SZ) : 1;
  localparam int T_W  = $clog2(S + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [T_W-1:0]   t_q, t_d;
  logic [AP_W-1:0]  a_ptr_q, a_ptr_d;
  logic [BP_W-1:0]  b_ptr_q, b_ptr_d;
  logic             a_full_q, a_full_d;
  logic             b_full_q, b_full_d;
  logic [DW-1:0]    a_mem_q [A_SZ];
  logic [DW-1:0]    a_mem_d [A_SZ];
  logic [DW-1:0]    b_mem_q [B_SZ];
  logic [DW-1:0]    b_mem_d [B_SZ];
  logic [M*DW-1:0]  a_edge_q, a_edge_d;
  logic [N*DW-1:0]  b_edge_q, b_edge_d;
  logic             edge_valid_q, edge_valid_d;
  logic             done_q, done_d;
  logic             a_wr, b_wr;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && a_full_q && b_full_q) begin
          state_d = ST_STREAM;
          t_d     = '0;
        end
      end
      ST_STREAM: begin
        if (t_q == T_W'(S - 1)) begin
          state_d = ST_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == ST_IDLE) && (in_sel ? !b_full_q : !a_full_q);
    busy     = (state_q != ST_IDLE);
  end

  assign a_wr = in_valid && in_ready && !in_sel;
  assign b_wr = in_valid && in_ready &&  in_sel;

  always_comb begin
    a_ptr_d  = a_ptr_q;
    b_ptr_d  = b_ptr_q;
    a_full_d = a_full_q;
    b_full_d = b_full_q;
    if (state_q == ST_DONE) begin
      a_ptr_d  = '0;
      b_ptr_d  = '0;
      a_full_d = 1'b0;
      b_full_d = 1'b0;
    end else begin
      if (a_wr) begin
        a_ptr_d = a_ptr_q + AP_W'(1);
        if (a_ptr_q == AP_W'(A_SZ - 1)) a_full_d = 1'b1;
      end
      if (b_wr) begin
        b_ptr_d = b_ptr_q + BP_W'(1);
        if (b_ptr_q == BP_W'(B_SZ - 1)) b_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
    end else begin
      a_ptr_q  <= a_ptr_d;
      b_ptr_q  <= b_ptr_d;
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
    end
  end

  // Buffer storage is not reset; the full flags gate every use of it.
  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (a_wr) a_mem_d[a_ptr_q[AI_W-1:0]] = in_data;
    if (b_wr) b_mem_d[b_ptr_q[BI_W-1:0]] = in_data;
  end

  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  // Lane i carries A[i][t-i], lane j carries B[t-j][j]; zero outside the skew window.
  always_comb begin
    a_edge_d     = '0;
    b_edge_d     = '0;
    edge_valid_d = (state_q == ST_STREAM);
    done_d       = (state_q == ST_DONE);
    if (state_q == ST_STREAM) begin
      for (int i = 0; i < M; i++) begin
        if ((int'(t_q) >= i) && (int'(t_q) - i < K))
          a_edge_d[i*DW +: DW] = a_mem_q[AI_W'(i*K + int'(t_q) - i)];
      end
      for (int j = 0; j < N; j++) begin
        if ((int'(t_q) >= j) && (int'(t_q) - j < K))
          b_edge_d[j*DW +: DW] = b_mem_q[BI_W'((int'(t_q) - j)*N + j)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_edge_q     <= '0;
      b_edge_q     <= '0;
      edge_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      a_edge_q     <= a_edge_d;
      b_edge_q     <= b_edge_d;
      edge_valid_q <= edge_valid_d;
      done_q       <= done_d;
    end
  end

  assign a_edge     = a_edge_q;
  assign b_edge     = b_edge_q;
  assign edge_valid = edge_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: expected wavefronts are queued at
// stimulus time and a negedge monitor pops and compares each valid wavefront.
module tb_systolic_feeder;

  localparam int M  = 4;
  localparam int K  = 4;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int S  = K + M + N - 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid, in_ready, in_sel, start;
  logic [DW-1:0]   in_data;
  logic [M*DW-1:0] a_edge;
  logic [N*DW-1:0] b_edge;
  logic            edge_valid, busy, done;

  systolic_feeder #(.M(M), .K(K), .N(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .start(start), .a_edge(a_edge),
    .b_edge(b_edge), .edge_valid(edge_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M*DW-1:0] a;
    logic [N*DW-1:0] b;
  } wf_t;

  wf_t             exp_q[$];
  logic [M*DW-1:0] log_a [256];
  logic [N*DW-1:0] log_b [256];
  int              wf_cnt = 0;
  int              done_cnt = 0;
  int              n_cmp = 0;
  int              n_err = 0;
  int              ta  [M*K];
  int              tbm [K*N];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (edge_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_wf: got wavefront %0d, expected none", wf_cnt);
        end else begin
          wf_t e;
          e = exp_q.pop_front();
          check("wf_a_edge", 64'(a_edge), 64'(e.a));
          check("wf_b_edge", 64'(b_edge), 64'(e.b));
        end
        if (wf_cnt < 256) begin
          log_a[wf_cnt] = a_edge;
          log_b[wf_cnt] = b_edge;
        end
        wf_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic beat(input logic sel, input int v);
    step();
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = DW'(v);
    #1;
    check("beat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_both();
    for (int k = 0; k < M*K; k++) begin
      beat(1'b0, ta[k]);
      beat(1'b1, tbm[k]);
    end
  endtask

  task automatic push_expected(input int nwf);
    for (int t = 0; t < nwf; t++) begin
      wf_t e;
      e = '0;
      for (int i = 0; i < M; i++)
        if (t - i >= 0 && t - i < K) e.a[i*DW +: DW] = DW'(ta[i*K + t - i]);
      for (int j = 0; j < N; j++)
        if (t - j >= 0 && t - j < K) e.b[j*DW +: DW] = DW'(tbm[(t - j)*N + j]);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bd);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_cnt > bd) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done pulse, expected one", nm);
    end else begin
      check({nm, "_valid_at_done"}, 64'(edge_valid), 64'd0);
      check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic run_stream(input string nm, output int base);
    int bd;
    push_expected(S);
    base = wf_cnt;
    bd   = done_cnt;
    pulse_start();
    wait_done(nm, bd);
    step();
    check({nm, "_wf_count"}, 64'(wf_cnt - base), 64'(S));
    check({nm, "_done_count"}, 64'(done_cnt - bd), 64'd1);
    check({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic quiet_window(input string nm, input int cycles);
    bit act = 1'b0;
    int base = wf_cnt;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (busy || edge_valid) act = 1'b1;
    end
    check({nm, "_busy_or_valid"}, 64'(act), 64'd0);
    check({nm, "_wf_count"}, 64'(wf_cnt - base), 64'd0);
  endtask

  initial begin
    int  base, bd;
    bit  bad, p3, p10;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_a_edge", 64'(a_edge), 64'd0);
    check("rst_b_edge", 64'(b_edge), 64'd0);
    check("rst_edge_valid", 64'(edge_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // A = 1..16, B = identity, interleaved beats
    for (int k = 0; k < 16; k++) begin
      ta[k]  = k + 1;
      tbm[k] = ((k / 4) == (k % 4)) ? 1 : 0;
    end
    load_both();
    run_stream("basic", base);
    check("basic_wf0_a", 64'(log_a[base]), 64'h0000_0001);
    check("basic_wf3_a", 64'(log_a[base + 3]), 64'h0d0a_0704);
    check("basic_wf2_b", 64'(log_b[base + 2]), 64'h0000_0100);
    bad = 1'b0;
    for (int t = 0; t < S; t++)
      if ((log_a[base + t][31:24] != 8'd0) != (t >= 3 && t <= 6)) bad = 1'b1;
    check("basic_lane3_window", 64'(bad), 64'd0);

    // start with B one beat short is ignored
    for (int k = 0; k < 16; k++) begin
      ta[k]  = 3*k - 20;
      tbm[k] = k + 100;
    end
    for (int k = 0; k < 16; k++) beat(1'b0, ta[k]);
    for (int k = 0; k < 15; k++) beat(1'b1, tbm[k]);
    pulse_start();
    quiet_window("partial", 15);
    beat(1'b1, tbm[15]);
    run_stream("partial", base);

    // 17th A beat stalls while B stays writable
    for (int k = 0; k < 16; k++) ta[k] = 20 + k;
    for (int k = 0; k < 16; k++) beat(1'b0, ta[k]);
    step();
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 8'd99;
    #1;
    check("a_full_ready_a", 64'(in_ready), 64'd0);
    repeat (3) step();
    in_valid = 1'b0;
    in_sel   = 1'b1;
    #1;
    check("a_full_ready_b", 64'(in_ready), 64'd1);
    for (int k = 0; k < 16; k++) beat(1'b1, tbm[k]);
    run_stream("overfill", base);
    check("overfill_wf0_lane0", 64'(log_a[base][7:0]), 64'd20);
    check("overfill_wf3_lane0", 64'(log_a[base + 3][7:0]), 64'd23);

    // sign-preserved extremes
    for (int k = 0; k < 16; k++) begin
      ta[k]  = k;
      tbm[k] = -k;
    end
    ta[0]  = -128;
    tbm[0] = -1;
    load_both();
    run_stream("negative", base);
    check("neg_wf0_a_lane0", 64'(log_a[base][7:0]), 64'h80);
    check("neg_wf0_b_lane0", 64'(log_b[base][7:0]), 64'hff);

    // reset in the middle of a stream
    for (int k = 0; k < 16; k++) begin
      ta[k]  = 50 - k;
      tbm[k] = 2*k - 9;
    end
    load_both();
    push_expected(4);
    base = wf_cnt;
    bd   = done_cnt;
    pulse_start();
    bad = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (wf_cnt - base == 4) begin
        bad = 1'b0;
        break;
      end
      step();
    end
    check("abort_reached_wf4", 64'(bad), 64'd0);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_a_edge", 64'(a_edge), 64'd0);
    check("abort_b_edge", 64'(b_edge), 64'd0);
    check("abort_edge_valid", 64'(edge_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check("abort_no_done", 64'(done_cnt - bd), 64'd0);
    check("abort_wf_count", 64'(wf_cnt - base), 64'd4);
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    in_sel = 1'b0;
    #1;
    check("abort_ready_a", 64'(in_ready), 64'd1);
    in_sel = 1'b1;
    #1;
    check("abort_ready_b", 64'(in_ready), 64'd1);
    pulse_start();
    quiet_window("abort_start", 15);
    load_both();
    run_stream("reload", base);

    // start pulses during STREAM and DONE are ignored
    for (int k = 0; k < 16; k++) begin
      ta[k]  = 7*k - 50;
      tbm[k] = 60 - 5*k;
    end
    load_both();
    push_expected(S);
    base = wf_cnt;
    bd   = done_cnt;
    pulse_start();
    p3  = 1'b0;
    p10 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      start = 1'b0;
      if (wf_cnt - base == 3 && !p3) begin
        start = 1'b1;
        p3    = 1'b1;
      end
      if (wf_cnt - base == S && !p10) begin
        start = 1'b1;
        p10   = 1'b1;
      end
    end
    start = 1'b0;
    quiet_window("restart_tail", 5);
    check("restart_wf_count", 64'(wf_cnt - base), 64'(S));
    check("restart_done_count", 64'(done_cnt - bd), 64'd1);
    check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
